// File: rtl/seq_pkg.sv
// Shared state encoding and default entry width for the sequence entry controller.
package seq_pkg;

  localparam int DAT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    REPLAY = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/nib_shift_buf.sv
// DEPTH x DAT_W shift buffer, entry 0 newest; load shifts up, clear zeroes all entries.
// Indexed read port is combinational; flat view is the raw register contents.
module nib_shift_buf
  import seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DAT_W = DAT_W_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   clr,
  input  logic [DAT_W-1:0]       din,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [DAT_W-1:0]       rd_dat,
  output logic [DAT_W*DEPTH-1:0] flat
);

  logic [DAT_W-1:0] ent [DEPTH];

  // clr together with load leaves din as the only non-zero entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (load) begin
      ent[0] <= din;
      for (int i = 1; i < DEPTH; i++) ent[i] <= clr ? '0 : ent[i-1];
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end
  end

  assign rd_dat = ent[rd_idx];

  always_comb begin
    flat = '0;
    for (int i = 0; i < DEPTH; i++) flat[i*DAT_W +: DAT_W] = ent[i];
  end

endmodule

// File: rtl/seq_entry_ctrl.sv
// Collects switch nibbles into a display buffer and replays them oldest-first to the analyzer.
// ANA_CE follows the GAP-th pacing tick by one cycle; display follows ADD by one cycle.
module seq_entry_ctrl
  import seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DAT_W = DAT_W_DEF,
  parameter int GAP   = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   TICK,
  input  logic                   BTN_ADD,
  input  logic                   BTN_RUN,
  input  logic [DAT_W-1:0]       DAT_IN,
  output logic                   ANA_CE,
  output logic [DAT_W-1:0]       ANA_DAT,
  output logic [DAT_W*DEPTH-1:0] HEX_OUT,
  output logic [DEPTH-1:0]       BLANK,
  output logic [3:0]             COUNT,
  output logic                   BUSY,
  output logic                   DONE_P,
  output logic                   FULL_ERR
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t            state, state_nxt;
  logic [3:0]        count, count_nxt;
  logic [3:0]        tick_cnt, tick_cnt_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic              last, last_nxt;
  logic              buf_load, buf_clr;
  logic              ce_nxt, done_nxt, full_nxt;
  logic [DAT_W-1:0]  dat_nxt, rd_dat;

  nib_shift_buf #(.DEPTH(DEPTH), .DAT_W(DAT_W), .IDX_W(IDX_W)) u_buf (
    .clk    (CLK),
    .rst    (RST),
    .load   (buf_load),
    .clr    (buf_clr),
    .din    (DAT_IN),
    .rd_idx (ptr),
    .rd_dat (rd_dat),
    .flat   (HEX_OUT)
  );

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    tick_cnt_nxt = tick_cnt;
    ptr_nxt      = ptr;
    last_nxt     = last;
    buf_load     = 1'b0;
    buf_clr      = 1'b0;
    ce_nxt       = 1'b0;
    done_nxt     = 1'b0;
    full_nxt     = 1'b0;
    dat_nxt      = ANA_DAT;
    case (state)
      IDLE: begin
        if (BTN_ADD) begin
          buf_load  = 1'b1;
          count_nxt = 4'd1;
          state_nxt = ENTRY;
        end
      end
      ENTRY, DONE: begin
        if (BTN_RUN) begin
          ptr_nxt      = IDX_W'(count - 4'd1);
          tick_cnt_nxt = '0;
          last_nxt     = 1'b0;
          state_nxt    = REPLAY;
        end else if (BTN_ADD && state == DONE) begin
          buf_load  = 1'b1;
          buf_clr   = 1'b1;
          count_nxt = 4'd1;
          state_nxt = ENTRY;
        end else if (BTN_ADD) begin
          if (count == 4'(DEPTH)) begin
            full_nxt = 1'b1;
          end else begin
            buf_load  = 1'b1;
            count_nxt = count + 4'd1;
          end
        end
      end
      REPLAY: begin
        // the cycle after the final pulse hands over to DONE
        if (last) begin
          last_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else if (TICK) begin
          if (tick_cnt == 4'(GAP - 1)) begin
            ce_nxt       = 1'b1;
            dat_nxt      = rd_dat;
            tick_cnt_nxt = '0;
            ptr_nxt      = ptr - IDX_W'(1);
            last_nxt     = (ptr == '0);
          end else begin
            tick_cnt_nxt = tick_cnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      count    <= '0;
      tick_cnt <= '0;
      ptr      <= '0;
      last     <= 1'b0;
      ANA_CE   <= 1'b0;
      ANA_DAT  <= '0;
      DONE_P   <= 1'b0;
      FULL_ERR <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      tick_cnt <= tick_cnt_nxt;
      ptr      <= ptr_nxt;
      last     <= last_nxt;
      ANA_CE   <= ce_nxt;
      ANA_DAT  <= dat_nxt;
      DONE_P   <= done_nxt;
      FULL_ERR <= full_nxt;
    end
  end

  always_comb begin
    BLANK = '1;
    for (int i = 0; i < DEPTH; i++) BLANK[i] = (4'(i) >= count);
  end

  assign COUNT = count;
  assign BUSY  = (state == REPLAY);

endmodule

// File: doc/seq_entry_ctrl.md
Name: seq_entry_ctrl

Overview:
- Sequencing controller between the filtered push-button pulses, the switch nibble, and the sequence analyzer.
- Collects up to DEPTH 4-bit switch values into a shift buffer and shows them on the 7-segment driver through a hex word and per-digit blank mask.
- On command, replays the buffered nibbles into the analyzer, oldest first, one clock-enable pulse per pacing tick.
- Sits after the button filters and the 1 kHz divider; feeds the analyzer CE/data inputs and the LED driver HEX/BLANK inputs.

Parameters:
- DEPTH, 8, number of buffered nibbles and display digits (2..8).
- DAT_W, 4, width of one entry.
- GAP, 1, pacing ticks between consecutive replay pulses (1..15).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- TICK  in  1  one-cycle pacing enable (1 kHz divider output).
- BTN_ADD  in  1  one-cycle filtered pulse: append DAT_IN.
- BTN_RUN  in  1  one-cycle filtered pulse: start replay.
- DAT_IN  in  DAT_W  switch value.
- ANA_CE  out  1  one-cycle clock enable to the analyzer.
- ANA_DAT  out  DAT_W  nibble presented with ANA_CE.
- HEX_OUT  out  DAT_W*DEPTH  display word; digit i is bits [4i+3:4i].
- BLANK  out  DEPTH  1 = digit off.
- COUNT  out  4  number of stored entries.
- BUSY  out  1  high in REPLAY.
- DONE_P  out  1  one-cycle pulse when replay completes.
- FULL_ERR  out  1  one-cycle pulse when ADD is rejected because the buffer is full.

Behaviour:
- Reset (RST=1 at a clock edge):
  - State IDLE.
  - Buffer, COUNT, HEX_OUT, ANA_DAT, tick counter and pointer are all 0.
  - BLANK all ones.
  - ANA_CE, BUSY, DONE_P and FULL_ERR are 0.
  - Reset during REPLAY aborts immediately; no further ANA_CE is issued.
- Buffer:
  - Entry 0 is the newest. ADD shifts entry i to i+1 and loads DAT_IN into entry 0.
  - COUNT increments, saturating at DEPTH.
  - HEX_OUT mirrors the buffer with registered, 1-cycle latency after the ADD edge.
  - BLANK[i] = (i >= COUNT).
  - Digits at i >= COUNT read 0.
- State machine (next state registered):
  - IDLE (COUNT=0):
    - ADD stores DAT_IN and moves to ENTRY.
    - RUN is ignored.
    - ADD together with RUN: ADD wins.
  - ENTRY:
    - ADD with COUNT<DEPTH stores the nibble.
    - ADD with COUNT=DEPTH leaves the buffer unchanged and pulses FULL_ERR for 1 cycle.
    - RUN loads ptr=COUNT-1, clears the tick counter, and moves to REPLAY.
    - ADD together with RUN: RUN wins and the ADD is dropped.
  - REPLAY (BUSY=1):
    - ADD and RUN are ignored.
    - On each TICK the tick counter increments. When it reaches GAP:
      - ANA_CE=1 for one cycle on the next cycle, with ANA_DAT = entry[ptr].
      - The counter clears and ptr decrements.
    - After the pulse for ptr=0, the next cycle goes to DONE with DONE_P=1 for that single cycle.
    - ANA_DAT holds its last value between pulses.
  - DONE:
    - Buffer and display are kept.
    - RUN starts a new replay of the same contents, as from ENTRY.
    - ADD clears the buffer, stores DAT_IN as the sole entry (COUNT=1), and moves to ENTRY.
    - ADD together with RUN: RUN wins.
- Timing:
  - RUN at cycle t puts BUSY high at t+1.
  - With GAP=1, each ANA_CE occurs exactly 1 cycle after a TICK seen in REPLAY.
  - A TICK coincident with the RUN cycle is not counted.
- Pulse inputs are assumed to be one cycle wide. The block does no edge detection; a level held for N cycles acts as N events.

Decomposition:
- Shared package (seq_pkg): the state encoding constants (IDLE=0, ENTRY=1, REPLAY=2, DONE=3) and the DAT_W default.
- One natural sub-module, nib_shift_buf: DEPTH x DAT_W shift register with load, clear and indexed read port.
- The FSM, pacing counter and output registers stay in seq_entry_ctrl.

Test Plan:
- Reset then idle: BLANK=8'hFF, HEX_OUT=0, COUNT=0. RUN pulse gives no BUSY and no ANA_CE.
- ADD 3 then ADD 5 then ADD A: COUNT=3, HEX_OUT=32'h0000035A, BLANK=8'hF8.
- Replay, GAP=1, buffer 3,5,A, TICK every 10 cycles: BUSY at t+1, then ANA_CE pulses with ANA_DAT=3, 5, A, each 1 cycle after successive TICKs. Then DONE_P once and BUSY low.
- Fill 8 entries (1..8), then ADD 9: FULL_ERR pulse, HEX_OUT=32'h12345678 unchanged, COUNT=8.
- Simultaneous events:
  - ADD+RUN in ENTRY starts replay and the ADD is dropped.
  - ADD+RUN in IDLE stores the entry (COUNT=1, no BUSY).
  - ADD in DONE with DAT_IN=C gives HEX_OUT=32'h0000000C, COUNT=1.
- RST asserted after the first ANA_CE of a 3-entry replay: no further ANA_CE, all outputs return to their reset values on the next cycle. GAP=3 variant: ANA_CE follows every third TICK.
